vj_integral_image: RTL and testbench



---
 rtl/vj_pkg.sv | 29 ++
 rtl/vj_line_buffer.sv | 28 ++
 rtl/vj_integral_image.sv | 168 ++++++++++++++++
 tb/tb_vj_integral_image.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vj_pkg.sv
// Shared constants, FSM state type and II address map for the Viola-Jones blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vj_pkg;

    localparam int VJ_IMG_W     = 320;
    localparam int VJ_IMG_H     = 240;
    localparam int VJ_II_W      = 321;
    localparam int VJ_ADDR_W    = 17;
    localparam int VJ_II_DATA_W = 32;
    localparam int VJ_PIX_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ZERO_ROW,
        ST_ROW_START,
        ST_PIXELS,
        ST_FINISH
    } vj_state_t;

    // Word address of ii(x,y); the rect-sum reader uses the same mapping.
    // pitch is a constant at every call site, so the multiply reduces to shift-add.
    function automatic logic [31:0] ii_addr(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [31:0] pitch);
        return y * pitch + x;
    endfunction

endpackage

// File: rtl/vj_line_buffer.sv
// One-row store of the previous integral-image row, indexed by column.
// Latency: combinational read, write takes effect at the next clock edge.
// Backpressure: none; a read and a write may hit the same index in one cycle (read returns old data).
module vj_line_buffer #(
    parameter int DEPTH  = 321,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Single write port; contents are not reset because a frame starts by zeroing every entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vj_integral_image.sv
// Streams raster pixels into a zero-padded integral image written to the shared II RAM.
// Latency: one registered write per accepted pixel, plus a zero row up front and a zero column word per row.
// Backpressure: pix_ready is high only while consuming pixels; the RAM side never stalls.
module vj_integral_image
    import vj_pkg::*;
#(
    parameter int IMG_W     = VJ_IMG_W,
    parameter int IMG_H     = VJ_IMG_H,
    parameter int II_W      = VJ_II_W,
    parameter int ADDR_W    = VJ_ADDR_W,
    parameter int II_DATA_W = VJ_II_DATA_W,
    parameter int PIX_W     = VJ_PIX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pix_valid,
    input  logic [PIX_W-1:0]     pix_data,
    output logic                 pix_ready,
    output logic                 ii_we,
    output logic [ADDR_W-1:0]    ii_waddr,
    output logic [II_DATA_W-1:0] ii_wdata,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(II_W);
    localparam int YW = $clog2(IMG_H + 1);

    localparam logic [CW-1:0] COL_LAST = CW'(II_W - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);

    vj_state_t            state;
    logic [CW-1:0]        col;
    logic [CW-1:0]        x;
    logic [YW-1:0]        y;
    logic [II_DATA_W-1:0] rowsum;

    logic                 accept;
    logic [CW-1:0]        x_nxt;
    logic [YW-1:0]        y_nxt;
    logic [II_DATA_W-1:0] pix_sum;
    logic [II_DATA_W-1:0] pix_val;
    logic [II_DATA_W-1:0] lb_rdata;
    logic                 lb_we;
    logic [CW-1:0]        lb_waddr;
    logic [II_DATA_W-1:0] lb_wdata;

    // pix_ready is a registered copy of "state is PIXELS", so it can gate acceptance directly.
    assign accept = pix_valid & pix_ready;
    assign x_nxt  = x + CW'(1);
    assign y_nxt  = y + YW'(1);

    // Running row prefix plus the word directly above gives ii at column x+1 of the current row.
    always_comb begin
        pix_sum = rowsum + II_DATA_W'(pix_data);
        pix_val = pix_sum + lb_rdata;
    end

    // Line buffer is zeroed during the zero row and then overwritten in place, column by column.
    always_comb begin
        lb_we    = 1'b0;
        lb_waddr = x_nxt;
        lb_wdata = pix_val;
        if (state == ST_ZERO_ROW) begin
            lb_we    = 1'b1;
            lb_waddr = col;
            lb_wdata = '0;
        end else if (accept) begin
            lb_we = 1'b1;
        end
    end

    vj_line_buffer #(
        .DEPTH  (II_W),
        .DATA_W (II_DATA_W),
        .AW     (CW)
    ) u_line_buffer (
        .clk    (clk),
        .we     (lb_we),
        .waddr  (lb_waddr),
        .wdata  (lb_wdata),
        .raddr  (x_nxt),
        .rdata  (lb_rdata)
    );

    // Frame FSM; every output is registered, so a write chosen this cycle shows on the port next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ii_we     <= 1'b0;
            ii_waddr  <= '0;
            ii_wdata  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_ready <= 1'b0;
            col       <= '0;
            x         <= '0;
            y         <= '0;
            rowsum    <= '0;
        end else begin
            ii_we <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state <= ST_ZERO_ROW;
                        busy  <= 1'b1;
                        col   <= '0;
                    end
                end
                ST_ZERO_ROW: begin
                    ii_we    <= 1'b1;
                    ii_waddr <= ADDR_W'(ii_addr(32'(col), 32'd0, 32'(II_W)));
                    ii_wdata <= '0;
                    col      <= col + CW'(1);
                    if (col == COL_LAST) begin
                        state <= ST_ROW_START;
                        y     <= '0;
                    end
                end
                ST_ROW_START: begin
                    // Column 0 of the row being built is always zero.
                    ii_we     <= 1'b1;
                    ii_waddr  <= ADDR_W'(ii_addr(32'd0, 32'(y_nxt), 32'(II_W)));
                    ii_wdata  <= '0;
                    rowsum    <= '0;
                    x         <= '0;
                    pix_ready <= 1'b1;
                    state     <= ST_PIXELS;
                end
                ST_PIXELS: begin
                    if (accept) begin
                        ii_we    <= 1'b1;
                        ii_waddr <= ADDR_W'(ii_addr(32'(x_nxt), 32'(y_nxt), 32'(II_W)));
                        ii_wdata <= pix_val;
                        rowsum   <= pix_sum;
                        x        <= x_nxt;
                        if (x == X_LAST) begin
                            pix_ready <= 1'b0;
                            if (y == Y_LAST) begin
                                state <= ST_FINISH;
                            end else begin
                                y     <= y_nxt;
                                state <= ST_ROW_START;
                            end
                        end
                    end
                end
                ST_FINISH: begin
                    // The final word is on the port this cycle; signal completion right after it.
                    pix_ready <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    pix_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vj_integral_image.sv
// Directed bench for vj_integral_image on a 4x3 image (II pitch 5, 20 II words).
// Expected II words come from a hand table and a brute-force rectangle-sum model.
// Frame latency is counted inclusive of the start cycle and the done cycle.
module tb_vj_integral_image;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int P  = 5;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int NP = W * H;
    localparam int NW = P * (H + 1);
    localparam int EXP_LAT = 1 + P + H * (W + 1) + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          pix_valid;
    logic [7:0]    pix_data;
    logic          pix_ready;
    logic          ii_we;
    logic [AW-1:0] ii_waddr;
    logic [DW-1:0] ii_wdata;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    vj_integral_image #(
        .IMG_W     (W),
        .IMG_H     (H),
        .II_W      (P),
        .ADDR_W    (AW),
        .II_DATA_W (DW),
        .PIX_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .ii_we     (ii_we),
        .ii_waddr  (ii_waddr),
        .ii_wdata  (ii_wdata),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        int addr;
        int val;
    } vec_t;

    int   checks = 0;
    int   failures = 0;

    int   shadow [NW];
    int   exp_ii [NW];
    logic [7:0] pix [NP];
    vec_t tbl [NW];

    int   cyc = 0;
    int   nwr, ndone, nready, nacc, mono_bad, done_busy_bad, last_addr;
    int   start_cyc, done_cyc;
    bit   arm = 1'b0;

    // Observer: samples outputs on the falling edge and records writes/events.
    always @(negedge clk) begin
        cyc++;
        if (arm && start) begin
            start_cyc = cyc;
            arm = 1'b0;
        end
        if (ii_we) begin
            if (nwr > 0 && int'(ii_waddr) <= last_addr) mono_bad++;
            last_addr = int'(ii_waddr);
            if (int'(ii_waddr) < NW) shadow[int'(ii_waddr)] = int'(ii_wdata);
            else mono_bad++;
            nwr++;
        end
        if (done) begin
            ndone++;
            done_cyc = cyc;
            if (busy) done_busy_bad++;
        end
        if (pix_ready) nready++;
        if (pix_ready && pix_valid) nacc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        nwr = 0; ndone = 0; nready = 0; nacc = 0; mono_bad = 0; done_busy_bad = 0;
        last_addr = -1; start_cyc = 0; done_cyc = 0;
        for (int i = 0; i < NW; i++) shadow[i] = -1;
    endtask

    // Brute-force ii(x,y) = sum of pix over columns < x and rows < y.
    task automatic build_ref();
        for (int yy = 0; yy <= H; yy++) begin
            for (int xx = 0; xx <= W; xx++) begin
                int s;
                s = 0;
                for (int j = 0; j < yy; j++)
                    for (int i = 0; i < xx; i++)
                        s += int'(pix[j * W + i]);
                exp_ii[yy * P + xx] = s;
            end
        end
    endtask

    task automatic compare_ref(input string tag);
        for (int a = 0; a < NW; a++)
            chk($sformatf("%s_ii[%0d]", tag, a), shadow[a], exp_ii[a]);
    endtask

    // Runs one frame: pulse start, stream pix[] (optionally with random gaps and
    // spurious start pulses), then wait for done; abort_at>=0 resets mid-frame.
    task automatic run_frame(input string tag, input bit gaps, input bit spam, input int abort_at);
        int idx;
        bit acc;
        clear_stats();
        arm = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_data  = pix_valid ? pix[0] : 8'($urandom);
        for (int t = 0; t < 400 && idx < NP; t++) begin
            @(negedge clk);
            acc = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (abort_at >= 0 && idx == abort_at) break;
            if (idx < NP) begin
                start     = spam ? 1'($urandom_range(0, 1)) : 1'b0;
                pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                pix_data  = pix_valid ? pix[idx] : 8'($urandom);
            end else begin
                start     = 1'b0;
                pix_valid = 1'b0;
            end
        end
        pix_valid = 1'b0;
        start = 1'b0;
        chk({tag, "_accepted"}, idx, (abort_at >= 0) ? abort_at : NP);
        if (abort_at >= 0) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            chk({tag, "_rst_busy"}, int'(busy), 0);
            chk({tag, "_rst_we"}, int'(ii_we), 0);
            chk({tag, "_rst_ready"}, int'(pix_ready), 0);
            chk({tag, "_rst_done"}, int'(done), 0);
        end else begin
            for (int t = 0; t < 30 && ndone == 0; t++) @(negedge clk);
            repeat (4) @(negedge clk);
            chk({tag, "_done_count"}, ndone, 1);
            chk({tag, "_done_busy_low"}, done_busy_bad, 0);
            chk({tag, "_writes"}, nwr, NW);
            chk({tag, "_monotonic"}, mono_bad, 0);
            chk({tag, "_accept_count"}, nacc, NP);
            chk({tag, "_busy_after"}, int'(busy), 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        // 4x3 frame with pixels 1..12; hand-computed II words by address.
        tbl = '{'{0, 0}, '{1, 0}, '{2, 0}, '{3, 0}, '{4, 0},
                '{5, 0}, '{6, 1}, '{7, 3}, '{8, 6}, '{9, 10},
                '{10, 0}, '{11, 6}, '{12, 14}, '{13, 24}, '{14, 36},
                '{15, 0}, '{16, 15}, '{17, 33}, '{18, 54}, '{19, 78}};

        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_we", int'(ii_we), 0);
        chk("reset_waddr", int'(ii_waddr), 0);
        chk("reset_wdata", int'(ii_wdata), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ready", int'(pix_ready), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Frame 1: ramp 1..12, no gaps; table check, exact latency, ready only in pixel cycles.
        for (int i = 0; i < NP; i++) pix[i] = 8'(i + 1);
        run_frame("ramp", 1'b0, 1'b0, -1);
        for (int i = 0; i < NW; i++)
            chk($sformatf("ramp_tbl[%0d]", tbl[i].addr), shadow[tbl[i].addr], tbl[i].val);
        chk("ramp_latency", done_cyc - start_cyc + 1, EXP_LAT);
        chk("ramp_ready_cycles", nready, NP);

        // Frame 2: all 255 with random valid gaps; largest value, no wrap.
        for (int i = 0; i < NP; i++) pix[i] = 8'd255;
        build_ref();
        run_frame("max", 1'b1, 1'b0, -1);
        compare_ref("max");
        chk("max_last_word", shadow[NW - 1], W * H * 255);

        // Frame 3: random pixels, gaps, start spammed while busy.
        for (int i = 0; i < NP; i++) pix[i] = 8'($urandom);
        build_ref();
        run_frame("spam", 1'b1, 1'b1, -1);
        compare_ref("spam");

        // Frame 4: new random pixels, reset after 7 accepts; frame 5 reruns them fully.
        for (int i = 0; i < NP; i++) pix[i] = 8'($urandom);
        build_ref();
        run_frame("abort", 1'b0, 1'b0, 7);
        run_frame("rerun", 1'b1, 1'b0, -1);
        compare_ref("rerun");

        // Frame 6: all ones, no gaps; every word is x*y.
        for (int i = 0; i < NP; i++) pix[i] = 8'd1;
        run_frame("ones", 1'b0, 1'b0, -1);
        for (int yy = 0; yy <= H; yy++)
            for (int xx = 0; xx <= W; xx++)
                chk($sformatf("ones_ii(%0d,%0d)", xx, yy), shadow[yy * P + xx], xx * yy);
        chk("ones_x0_y1", shadow[P], 0);
        chk("ones_latency", done_cyc - start_cyc + 1, EXP_LAT);
        chk("ones_ready_cycles", nready, NP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
